// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size encodings, MMIO offsets, TCON bit indices and FSM states for data_mem_mmio
package data_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [4:0] OFF_TH = 5'h00;
  localparam logic [4:0] OFF_TL = 5'h04;
  localparam logic [4:0] OFF_TCON = 5'h08;
  localparam logic [4:0] OFF_LED = 5'h0C;
  localparam logic [4:0] OFF_DIGI = 5'h10;
  localparam int TC_EN = 0;
  localparam int TC_IE = 1;
  localparam int TC_ST = 2;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: reloading 32-bit up-counter with interrupt status
// ports: clk, rst (sync, high); we_th/we_tl/we_tcon + wdata from the CPU; th, tl, tcon {status, irq_en, enable}; irq
module mmio_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  import data_mem_pkg::*;
  logic ovf;
  assign ovf = tcon[TC_EN] && &tl;
  assign irq = tcon[TC_IE] && tcon[TC_ST];
  always_ff @(posedge clk)
    if (rst) begin
      th <= '0;
      tl <= '0;
      tcon <= '0;
    end else begin
      if (we_th) th <= wdata;
      tl <= we_tl ? wdata : ovf ? th : tl + 32'(tcon[TC_EN]);
      // an overflow landing on a TCON write still raises status so no interrupt is lost
      if (we_tcon) tcon <= {wdata[TC_ST] | (ovf & tcon[TC_IE]), wdata[TC_IE:TC_EN]};
      else if (ovf) tcon[TC_ST] <= tcon[TC_IE];
    end
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: MEM-stage data RAM with byte/half/word lanes, clear sequencer and MMIO registers
// ports: clk, rst (sync, high); MemRd/MemWr/MemSize/MemSigned/Addr/WrData access; RdData, AddrErr (combinational);
//        Busy while clearing; RAM_Digi, RAM_Led registers; Irq from the timer
// MMIO_TIMER_EN: when defined, instantiates mmio_timer (TH/TL/TCON, Irq); otherwise those read 0 and Irq is 0
module data_mem_mmio #(
  parameter int          RAM_SIZE       = 512,
  parameter int          RAM_ADDR_WIDTH = 9,
  parameter logic [31:0] MMIO_BASE      = 32'h4000_0000,
  parameter int          DIGI_WIDTH     = 12,
  parameter int          LED_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRd,
  input  logic                  MemWr,
  input  logic [1:0]            MemSize,
  input  logic                  MemSigned,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WrData,
  output logic [31:0]           RdData,
  output logic                  AddrErr,
  output logic                  Busy,
  output logic [DIGI_WIDTH-1:0] RAM_Digi,
  output logic [LED_WIDTH-1:0]  RAM_Led,
  output logic                  Irq
);
  import data_mem_pkg::*;
  logic [31:0] ram [RAM_SIZE];
  state_t state;
  logic [RAM_ADDR_WIDTH-1:0] clr_ptr, widx;
  logic [4:0] off, sh;
  logic [31:0] word, lane, mask, wmerge, ram_rd, io_rd, th, tl;
  logic [2:0] tcon;
  logic in_ram, in_io, is_word, misalign, bad, wr_ok, wr_io;
  assign Busy = state == ST_CLEAR;
  assign is_word = MemSize >= SZ_WORD;
  assign in_ram = Addr[31:2] < 30'(RAM_SIZE);
  assign in_io = Addr[31:5] == MMIO_BASE[31:5];
  assign off = Addr[4:0];
  assign misalign = is_word ? |Addr[1:0] : MemSize == SZ_HALF && Addr[0];
  assign bad = misalign || !(in_ram || in_io) || (in_io && !is_word);
  assign AddrErr = (MemRd || MemWr) && bad;
  assign wr_ok = MemWr && !bad && !Busy;
  assign wr_io = wr_ok && in_io;
  assign widx = Addr[RAM_ADDR_WIDTH+1:2];
  assign sh = {Addr[1:0], 3'b000};
  assign word = ram[widx];
  // store lanes merged into the old word; the read port sees the pre-write value
  assign mask = (MemSize == SZ_BYTE ? 32'h0000_00FF : MemSize == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
  assign wmerge = (word & ~mask) | ((WrData << sh) & mask);
  assign lane = word >> sh;
  assign ram_rd = MemSize == SZ_BYTE ? {{24{MemSigned & lane[7]}}, lane[7:0]} :
                  MemSize == SZ_HALF ? {{16{MemSigned & lane[15]}}, lane[15:0]} : lane;
  assign io_rd = off == OFF_TH ? th : off == OFF_TL ? tl : off == OFF_TCON ? 32'(tcon) :
                 off == OFF_LED ? 32'(RAM_Led) : off == OFF_DIGI ? 32'(RAM_Digi) : '0;
  assign RdData = (bad || Busy) ? '0 : in_io ? io_rd : ram_rd;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_CLEAR;
      clr_ptr <= '0;
      RAM_Led <= '0;
      RAM_Digi <= '0;
    end else begin
      if (Busy) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == RAM_ADDR_WIDTH'(RAM_SIZE - 1)) state <= ST_IDLE;
      end
      if (wr_io && off == OFF_LED) RAM_Led <= WrData[LED_WIDTH-1:0];
      if (wr_io && off == OFF_DIGI) RAM_Digi <= WrData[DIGI_WIDTH-1:0];
    end
  // kept free of reset so the array maps onto block RAM
  always_ff @(posedge clk)
    if (!rst) begin
      if (Busy) ram[clr_ptr] <= '0;
      else if (wr_ok && in_ram) ram[widx] <= wmerge;
    end
`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk(clk),
    .rst(rst),
    .we_th(wr_io && off == OFF_TH),
    .we_tl(wr_io && off == OFF_TL),
    .we_tcon(wr_io && off == OFF_TCON),
    .wdata(WrData),
    .th(th),
    .tl(tl),
    .tcon(tcon),
    .irq(Irq)
  );
`else
  assign th = '0;
  assign tl = '0;
  assign tcon = '0;
  assign Irq = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: scoreboard bench with a byte-addressed reference model for data_mem_mmio
module tb_data_mem_mmio;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 0, rst = 0, MemRd = 0, MemWr = 0, MemSigned = 0;
  logic [1:0] MemSize = 0;
  logic [31:0] Addr = 0, WrData = 0, RdData;
  logic AddrErr, Busy, Irq;
  logic [11:0] RAM_Digi;
  logic [7:0] RAM_Led;
  data_mem_mmio dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .MemSize(MemSize), .MemSigned(MemSigned),
    .Addr(Addr), .WrData(WrData), .RdData(RdData), .AddrErr(AddrErr), .Busy(Busy),
    .RAM_Digi(RAM_Digi), .RAM_Led(RAM_Led), .Irq(Irq)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] rd; logic err; logic chk_rd;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit [7:0] mb [2048];
  bit m_busy = 0;
  bit [7:0] m_led = 0;
  bit [11:0] m_digi = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (MemRd || MemWr) begin
      exp_t e;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: access at %h with no expectation queued", Addr);
      end else begin
        e = q.pop_front();
        chk($sformatf("AddrErr @%h", Addr), 32'(AddrErr), 32'(e.err));
        if (e.chk_rd) chk($sformatf("RdData @%h", Addr), RdData, e.rd);
      end
    end

  task automatic drive(bit rd, bit wr, bit [1:0] sz, bit sg, bit [31:0] a, bit [31:0] wd, bit [31:0] er, bit ee);
    MemRd = rd; MemWr = wr; MemSize = sz; MemSigned = sg; Addr = a; WrData = wd;
    if (rd || wr) q.push_back(exp_t'{er, ee, rd});
    @(posedge clk); #1;
    MemRd = 0; MemWr = 0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic op(bit rd, bit wr, bit [1:0] sz, bit sg, bit [31:0] a, bit [31:0] wd = 0);
    int n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    bit in_ram = a < 2048;
    bit in_io = a >= BASE && a < BASE + 32;
    bit [31:0] off = a - BASE;
    bit [31:0] r = 0;
    bit e;
    e = (a % n != 0) || !(in_ram || in_io) || (in_io && n != 4);
    if (!e && !m_busy) begin
      if (in_ram) begin
        for (int i = 0; i < n; i++) r |= 32'(mb[a + i]) << (8 * i);
        if (sg && n < 4 && r[8 * n - 1]) r |= 32'hFFFF_FFFF << (8 * n);
      end else r = off == 12 ? 32'(m_led) : off == 16 ? 32'(m_digi) : 0;
      if (wr) begin
        if (in_ram) for (int i = 0; i < n; i++) mb[a + i] = wd[8 * i +: 8];
        else if (off == 12) m_led = wd[7:0];
        else if (off == 16) m_digi = wd[11:0];
      end
    end
    drive(rd, wr, sz, sg, a, wd, r, e);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_busy = 1; m_led = 0; m_digi = 0;
    foreach (mb[i]) mb[i] = 0;
    chk("Busy after reset", 32'(Busy), 1);
  endtask

  task automatic wait_clear(string nm);
    int c = 0;
    while (Busy && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, c, 512);
    m_busy = 0;
  endtask

  task automatic rand_op();
    int k = $urandom_range(0, 9);
    bit [31:0] a;
`ifdef MMIO_TIMER_EN
    int lo = 3;
`else
    int lo = 0;
`endif
    if (k < 6) a = $urandom_range(0, 63);
    else if (k < 7) a = $urandom_range(0, 2047);
    else if (k < 8) a = $urandom_range(2040, 2055);
    else if (k < 9) a = BASE + 4 * $urandom_range(lo, 7) + ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    else a = $urandom();
    op($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, a, $urandom());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    op(0, 1, 2, 0, 32'h14, 32'hDEAD_BEEF);
    do_reset();
    chk("Led reset", 32'(RAM_Led), 0);
    chk("Digi reset", 32'(RAM_Digi), 0);
    chk("Irq reset", 32'(Irq), 0);
    wait_clear("clear cycles");
    op(1, 0, 2, 0, 32'h14);
    op(0, 1, 2, 0, 32'h8, 32'h1122_3344);
    op(0, 1, 0, 0, 32'h9, 32'h0000_00AA);
    op(1, 0, 2, 0, 32'h8);
    op(1, 0, 0, 1, 32'h9);
    op(1, 0, 0, 0, 32'h9);
    op(0, 1, 1, 0, 32'h3, 32'h0000_BEEF);
    op(1, 0, 2, 0, 32'h0);
    op(1, 0, 2, 0, 32'h2000);
    op(0, 1, 2, 0, BASE + 16, 32'h0000_0ABC);
    chk("Digi write", 32'(RAM_Digi), 32'hABC);
    op(0, 1, 2, 0, BASE + 12, 32'h0000_005A);
    chk("Led write", 32'(RAM_Led), 32'h5A);
    op(1, 1, 2, 0, 32'h8, 32'h5566_7788);
    op(1, 0, 2, 0, 32'h8);
    op(1, 0, 1, 1, 32'h7FE);
    op(1, 0, 2, 0, 32'h800);
    op(1, 0, 2, 0, BASE + 32);
    op(1, 0, 2, 0, BASE - 4);
    op(1, 0, 0, 0, BASE + 12);
    op(1, 0, 2, 0, BASE + 20);
`ifndef MMIO_TIMER_EN
    op(0, 1, 2, 0, BASE + 8, 32'h3);
    op(0, 1, 2, 0, BASE + 0, 32'h5);
    op(0, 1, 2, 0, BASE + 4, 32'h7);
    idle();
    op(1, 0, 2, 0, BASE + 0);
    op(1, 0, 2, 0, BASE + 4);
    op(1, 0, 2, 0, BASE + 8);
    chk("Irq without timer", 32'(Irq), 0);
`endif
    repeat (300) rand_op();
    chk("Led after random", 32'(RAM_Led), 32'(m_led));
    chk("Digi after random", 32'(RAM_Digi), 32'(m_digi));
    do_reset();
    op(0, 1, 2, 0, BASE + 12, 32'h0000_00FF);
    op(1, 0, 2, 0, BASE + 12);
    op(1, 0, 2, 0, 32'h8);
    repeat (97) idle();
    chk("Led write ignored while busy", 32'(RAM_Led), 0);
    do_reset();
    wait_clear("clear cycles after mid-clear reset");
    op(1, 0, 2, 0, 32'h8);
`ifdef MMIO_TIMER_EN
    drive(1, 0, 2, 0, BASE + 0, 0, 0, 0);
    drive(1, 0, 2, 0, BASE + 4, 0, 0, 0);
    drive(1, 0, 2, 0, BASE + 8, 0, 0, 0);
    drive(0, 1, 2, 0, BASE + 0, 32'hFFFF_FFF0, 0, 0);
    drive(0, 1, 2, 0, BASE + 4, 32'hFFFF_FFFE, 0, 0);
    drive(0, 1, 2, 0, BASE + 8, 32'h3, 0, 0);
    idle();
    chk("Irq before overflow", 32'(Irq), 0);
    idle();
    chk("Irq after overflow", 32'(Irq), 1);
    drive(1, 0, 2, 0, BASE + 4, 0, 32'hFFFF_FFF0, 0);
    drive(0, 1, 2, 0, BASE + 8, 32'h3, 0, 0);
    chk("Irq after status clear", 32'(Irq), 0);
    drive(0, 1, 2, 0, BASE + 4, 32'hFFFF_FFFF, 0, 0);
    drive(0, 1, 2, 0, BASE + 8, 32'h2, 0, 0);
    chk("Irq with TCON write in overflow", 32'(Irq), 1);
    drive(1, 0, 2, 0, BASE + 8, 0, 32'h6, 0);
    drive(1, 0, 2, 0, BASE + 4, 0, 32'hFFFF_FFF0, 0);
`endif
    idle();
    chk("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
